// File: rtl/mem_arb2_pkg.sv
// Shared memory-bus types and arbiter state encoding.
// Payload structs, data widths, access type and arbiter FSM states.
package mem_arb2_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] req_addr;
    logic [MEM_DATA_W-1:0] req_data;
    logic [MEM_MASK_W-1:0] req_mask;
    mem_type_e             req_type;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] resp_data;
  } mem_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/mem_arb2_rr.sv
// Two-way round-robin grant: one-hot gnt from req, pointer moves on update.
// Ports: clk, rst, req[1:0], update, gnt[1:0].
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 = m1 was granted last; reset value lets m0 win the first tie
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      req[0] && (!req[1] || last_q): gnt = 2'b01;
      req[1] && (!req[0] || !last_q): gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update && (gnt != 2'b00))
      last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/mem_arb2.sv
// Two-master to one-slave memory arbiter, one transaction in flight.
// Ports: m0/m1 req+resp handshakes, slave req+resp, timeout_err pulse.
module mem_arb2
  import mem_arb2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      m0_req_valid,
  output logic      m0_req_ready,
  input  mem_req_t  m0_req,
  output logic      m0_resp_valid,
  input  logic      m0_resp_ready,
  output mem_resp_t m0_resp,
  input  logic      m1_req_valid,
  output logic      m1_req_ready,
  input  mem_req_t  m1_req,
  output logic      m1_resp_valid,
  input  logic      m1_resp_ready,
  output mem_resp_t m1_resp,
  output logic      s_req_valid,
  input  logic      s_req_ready,
  output mem_req_t  s_req,
  input  logic      s_resp_valid,
  output logic      s_resp_ready,
  input  mem_resp_t s_resp,
  output logic      timeout_err
);

  arb_state_e            state_q, state_d;
  logic                  gid_q, gid_d;
  mem_req_t              req_q, req_d;
  logic [MEM_DATA_W-1:0] data_q, data_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [1:0]            gnt;
  logic                  upd;
  logic                  idle;
  logic                  tmo;

  assign idle = (state_q == ARB_IDLE);
  assign upd  = idle && (gnt != 2'b00);
  assign tmo  = (cnt_q == 16'(TIMEOUT_CYC - 1));

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1_req_valid, m0_req_valid}),
    .update (upd),
    .gnt    (gnt)
  );

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (upd) begin
          gid_d   = gnt[1];
          req_d   = gnt[1] ? m1_req : m0_req;
          cnt_d   = '0;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (tmo) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end else if (s_req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // a real response beats a coinciding timeout
        if (s_resp_valid) begin
          data_d  = s_resp.resp_data;
          state_d = ARB_RESP;
        end else if (tmo) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (gid_q ? m1_resp_ready : m0_resp_ready)
          state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gid_q   <= 1'b0;
      req_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign m0_req_ready  = idle && gnt[0];
  assign m1_req_ready  = idle && gnt[1];
  assign s_req_valid   = (state_q == ARB_REQ);
  assign s_req         = req_q;
  assign s_resp_ready  = (state_q == ARB_WAIT);
  assign m0_resp_valid = (state_q == ARB_RESP) && !gid_q;
  assign m1_resp_valid = (state_q == ARB_RESP) && gid_q;
  assign m0_resp       = '{resp_data: data_q};
  assign m1_resp       = '{resp_data: data_q};
  assign timeout_err   = err_q;

endmodule
